reg_op_driver: RTL and testbench
================================

REG_OP_DRIVER -- requirements
Module: reg_op_driver

Interface
REQ-001 SHALL have parameter N, default 8, meaning the data width of the driven register.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 SHALL have port cmd_op, input, 2 bits: the operation, encoded 00 decrement, 01 increment, 10 load, 11 clear.
REQ-007 SHALL have port cmd_data, input, N bits: the load value, used only when cmd_op is 10.
REQ-008 SHALL have port cmd_rep, input, 4 bits: the repeat count; value 0 is treated as 1.
REQ-009 SHALL have ports E, FunSel[1:0] and I[N-1:0], outputs, driving the register's enable, function select and input.
REQ-010 SHALL have port Q, input, N bits: the register output, read back.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse when a command completes.
REQ-012 SHALL have port mismatch, output, 1 bit: sticky flag, set when a read-back error is detected.
REQ-013 SHALL have port err_count, output, 8 bits: the number of read-back errors, saturating at 255.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE, CHECK and DONE.
REQ-015 IDLE SHALL assert cmd_ready; on cmd_valid&&cmd_ready it SHALL latch op/data/rep and go to ISSUE the next cycle.
REQ-016 ISSUE SHALL drive E=1, FunSel=latched op and I=latched data for exactly one cycle, then go to CHECK.
REQ-017 Outside ISSUE, E SHALL be 0; FunSel and I SHALL hold their last value.
REQ-018 CHECK SHALL compare Q against the shadow prediction, decrement the remaining count, and go to ISSUE if the count is nonzero, else to DONE.
REQ-019 DONE SHALL pulse done for one cycle and return to IDLE; a command takes 2*rep+2 cycles from acceptance to the done pulse.
REQ-020 The shadow model SHALL update at each ISSUE cycle with mod-2^N arithmetic: decrement wraps 0 to 2^N-1, increment wraps 2^N-1 to 0, load sets data, clear sets 0.
REQ-021 A mismatch in CHECK SHALL set mismatch and increment err_count (saturating); matches SHALL leave both unchanged.
REQ-022 cmd_valid outside IDLE SHALL be ignored; the command SHALL NOT be latched.
REQ-023 The shadow model SHALL be undefined until the first load or clear; compares before that SHALL be suppressed (tracked by an internal "known" bit).

Reset
REQ-024 Reset_n low SHALL asynchronously force: state IDLE, E=0, FunSel=00, I=0, done=0, mismatch=0, err_count=0, known=0, and count=0.
REQ-025 Reset asserted mid-command SHALL abort the command with no done pulse; after release the block SHALL be in IDLE with cmd_ready=1.

Configuration
REQ-026 Macro REG_OP_DRIVER_CHECK_EN defined SHALL compile in the shadow model, the compare, mismatch and err_count per REQ-020 to REQ-023.
REQ-027 Without REG_OP_DRIVER_CHECK_EN, mismatch and err_count SHALL be tied to 0, no shadow logic SHALL exist, and the FSM timing SHALL be unchanged.

Verification
REQ-028 Reset, then load 0xAA with rep=1 -> one ISSUE cycle with E=1, FunSel=10, I=0xAA; done pulses 4 cycles after acceptance; mismatch=0.
REQ-029 After clear, decrement with rep=3 -> three E pulses with FunSel=00, each separated by a CHECK cycle; Q reads 0xFF, 0xFE, 0xFD; no mismatch.
REQ-030 Load 0xFF, then increment with rep=0 -> exactly one increment; Q=0x00 (wrap); done pulses 4 cycles after acceptance.
REQ-031 With the register model forced to hold Q=0x00 after load 0x55 -> mismatch=1 and err_count=1; both stay set through the following commands until reset.
REQ-032 Assert Reset_n low during the second ISSUE of a rep=4 command -> E=0 immediately, no done pulse, and cmd_ready=1 after release; cmd_valid pulsed in CHECK is ignored.
REQ-033 Build without REG_OP_DRIVER_CHECK_EN and repeat REQ-031 -> mismatch=0, err_count=0, and identical E/FunSel timing.

Source files
------------

// File: rtl/reg_op_driver.sv
// reg_op_driver: issues decrement/increment/load/clear commands to an external register and checks its read-back value.
// Optional build macro REG_OP_DRIVER_CHECK_EN enables the shadow model, the compare, mismatch and err_count.  Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module reg_op_driver #(
   parameter int N = 8
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_data,
   input  logic [3:0]   cmd_rep,
   output logic         E,
   output logic [1:0]   FunSel,
   output logic [N-1:0] I,
   input  logic [N-1:0] Q,
   output logic         done,
   output logic         mismatch,
   output logic [7:0]   err_count
);

   localparam logic [1:0] c_OP_DEC  = 2'b00;
   localparam logic [1:0] c_OP_INC  = 2'b01;
   localparam logic [1:0] c_OP_LOAD = 2'b10;
   localparam logic [1:0] c_OP_CLR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic           w_accept;
   logic           w_ready;
   logic [1:0]     w_issue_op;
   logic [N-1:0]   w_issue_data;

   logic [1:0]     r_op;
   logic [N-1:0]   r_data;
   logic [3:0]     r_count;
   logic           r_e;
   logic [1:0]     r_funsel;
   logic [N-1:0]   r_i;
   logic           r_done;

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_issue_op   = r_op;
      w_issue_data = r_data;
      case (r_state)
         S_IDLE: begin
            w_ready      = 1'b1;
            w_accept     = cmd_valid;
            // first ISSUE follows acceptance directly, so take op/data from the port
            w_issue_op   = cmd_op;
            w_issue_data = cmd_data;
            if (cmd_valid) begin
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next_state = S_CHECK;
         end
         S_CHECK: begin
            if (r_count == 4'd1) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_ISSUE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state  <= S_IDLE;
         r_op     <= 2'b00;
         r_data   <= '0;
         r_count  <= 4'd0;
         r_e      <= 1'b0;
         r_funsel <= 2'b00;
         r_i      <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= (r_state == S_DONE);
         r_e     <= (w_next_state == S_ISSUE);
         if (w_accept) begin
            r_op    <= cmd_op;
            r_data  <= cmd_data;
            r_count <= (cmd_rep == 4'd0) ? 4'd1 : cmd_rep;
         end
         if (w_next_state == S_ISSUE) begin
            r_funsel <= w_issue_op;
            r_i      <= w_issue_data;
         end
         if (r_state == S_CHECK) begin
            r_count <= r_count - 4'd1;
         end
      end
   end

   assign cmd_ready = w_ready;
   assign E         = r_e;
   assign FunSel    = r_funsel;
   assign I         = r_i;
   assign done      = r_done;

`ifdef REG_OP_DRIVER_CHECK_EN
   logic [N-1:0] r_shadow;
   logic         r_known;
   logic         r_mismatch;
   logic [7:0]   r_err_count;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_shadow    <= '0;
         r_known     <= 1'b0;
         r_mismatch  <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         if (r_state == S_ISSUE) begin
            case (r_op)
               c_OP_DEC:  r_shadow <= r_shadow - N'(1);
               c_OP_INC:  r_shadow <= r_shadow + N'(1);
               c_OP_LOAD: r_shadow <= r_data;
               c_OP_CLR:  r_shadow <= '0;
            endcase
            if (r_op[1]) begin
               r_known <= 1'b1;
            end
         end
         // the register is sampled the cycle after its enable, which is CHECK
         if ((r_state == S_CHECK) && r_known && (Q != r_shadow)) begin
            r_mismatch <= 1'b1;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
      end
   end

   assign mismatch  = r_mismatch;
   assign err_count = r_err_count;
`else
   logic w_unused_q;
   assign w_unused_q = ^Q;
   assign mismatch   = 1'b0;
   assign err_count  = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_op_driver.sv
// tb_reg_op_driver: drives reg_op_driver against a simple register model and checks it with a behavioural reference.
`timescale 1ns/1ps
`default_nettype none

module tb_reg_op_driver;
   localparam int N = 8;

`ifdef REG_OP_DRIVER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         Clock = 1'b0;
   logic         Reset_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [N-1:0] cmd_data = '0;
   logic [3:0]   cmd_rep = 4'd0;
   logic         E;
   logic [1:0]   FunSel;
   logic [N-1:0] I;
   logic [N-1:0] Q;
   logic         done;
   logic         mismatch;
   logic [7:0]   err_count;

   logic [N-1:0] reg_q = '0;
   bit           stuck = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [N-1:0] ref_val = '0;
   bit           ref_known = 1'b0;
   bit           ref_mm = 1'b0;
   int           ref_err = 0;

   reg_op_driver #(.N(N)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_rep   (cmd_rep),
      .E         (E),
      .FunSel    (FunSel),
      .I         (I),
      .Q         (Q),
      .done      (done),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   always #5 Clock = ~Clock;

   // external register being driven
   always @(posedge Clock) begin
      if (E) begin
         case (FunSel)
            2'b00: reg_q <= reg_q - 8'd1;
            2'b01: reg_q <= reg_q + 8'd1;
            2'b10: reg_q <= I;
            default: reg_q <= 8'd0;
         endcase
      end
   end
   assign Q = stuck ? '0 : reg_q;

   function automatic logic [N-1:0] apply_op(input logic [1:0] op, input logic [N-1:0] d,
                                               input logic [N-1:0] v);
      int r;
      case (op)
         2'b00:   r = (int'(v) + 255) % 256;
         2'b01:   r = (int'(v) + 1) % 256;
         2'b10:   r = int'(d);
         default: r = 0;
      endcase
      return N'(r);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] data, input logic [3:0] rep,
                          input bit inject);
      int reps;
      int total;
      bit is_issue;
      bit is_check;
      logic [N-1:0] exp_q;
      reps  = (rep == 4'd0) ? 1 : int'(rep);
      total = 2 * reps + 2;
      @(negedge Clock);
      check("ready_before", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_rep   = rep;
      @(posedge Clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = N'($urandom);
      cmd_rep   = 4'($urandom);
      for (int c = 1; c <= total; c++) begin
         @(negedge Clock);
         is_issue = (c % 2 == 1) && (c <= 2 * reps - 1);
         is_check = (c % 2 == 0) && (c <= 2 * reps);
         check("E", 32'(E), 32'(is_issue));
         check("FunSel", 32'(FunSel), 32'(op));
         check("I", 32'(I), 32'(data));
         check("ready", 32'(cmd_ready), 32'(c == total));
         check("done", 32'(done), 32'(c == total));
         if (is_issue) begin
            ref_val = apply_op(op, data, ref_val);
            if (op == 2'b10 || op == 2'b11) ref_known = 1'b1;
         end
         if (is_check) begin
            exp_q = stuck ? '0 : ref_val;
            check("Q", 32'(Q), 32'(exp_q));
            if (CHK && ref_known && exp_q != ref_val) begin
               ref_mm = 1'b1;
               if (ref_err < 255) ref_err++;
            end
         end
         if (inject && c == 2) begin
            cmd_valid = 1'b1;
            cmd_op    = ~op;
            cmd_data  = ~data;
            cmd_rep   = 4'd7;
         end
         if (inject && c == 3) begin
            cmd_valid = 1'b0;
         end
      end
      check("mismatch", 32'(mismatch), 32'(ref_mm));
      check("err_count", 32'(err_count), 32'(ref_err));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (3) @(negedge Clock);
      check("rst_E", 32'(E), 32'd0);
      check("rst_FunSel", 32'(FunSel), 32'd0);
      check("rst_I", 32'(I), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      Reset_n = 1'b1;

      // load 0xAA, rep 1
      run_cmd(2'b10, 8'hAA, 4'd1, 1'b0);
      check("load_aa_q", 32'(Q), 32'h0000_00AA);

      // clear then decrement x3 with a command offered during CHECK
      run_cmd(2'b11, N'($urandom), 4'd1, 1'b0);
      run_cmd(2'b00, N'($urandom), 4'd3, 1'b1);
      check("dec3_q", 32'(Q), 32'h0000_00FD);

      // load 0xFF, increment with rep 0 wraps to 0
      run_cmd(2'b10, 8'hFF, 4'd1, 1'b0);
      run_cmd(2'b01, N'($urandom), 4'd0, 1'b0);
      check("inc_wrap_q", 32'(Q), 32'd0);

      // random commands
      for (int k = 0; k < 12; k++) begin
         run_cmd(2'($urandom), N'($urandom), 4'($urandom_range(0, 5)), 1'($urandom));
      end

      // register stuck at 0 during a load of 0x55
      stuck = 1'b1;
      run_cmd(2'b10, 8'h55, 4'd1, 1'b0);
      stuck = 1'b0;
      check("stuck_mm", 32'(mismatch), 32'(CHK));
      check("stuck_err", 32'(err_count), CHK ? 32'd1 : 32'd0);
      for (int k = 0; k < 3; k++) begin
         run_cmd(2'($urandom), N'($urandom), 4'($urandom_range(1, 3)), 1'b0);
      end
      check("sticky_mm", 32'(mismatch), 32'(CHK));
      check("sticky_err", 32'(err_count), CHK ? 32'd1 : 32'd0);

      // reset during the second ISSUE of a rep=4 increment
      @(negedge Clock);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = N'($urandom);
      cmd_rep   = 4'd4;
      @(posedge Clock);
      #1 cmd_valid = 1'b0;
      ref_val = apply_op(2'b01, 8'h00, ref_val);
      @(posedge Clock);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      check("abort_check_ready", 32'(cmd_ready), 32'd0);
      @(posedge Clock);
      #1 cmd_valid = 1'b0;
      check("abort_issue2_E", 32'(E), 32'd1);
      check("abort_issue2_fs", 32'(FunSel), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("abort_E", 32'(E), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_FunSel", 32'(FunSel), 32'd0);
      check("abort_I", 32'(I), 32'd0);
      check("abort_mm", 32'(mismatch), 32'd0);
      check("abort_err", 32'(err_count), 32'd0);
      ref_mm    = 1'b0;
      ref_err   = 0;
      ref_known = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         check("abort_no_done", 32'(done), 32'd0);
      end
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clock);
         check("post_ready", 32'(cmd_ready), 32'd1);
         check("post_done", 32'(done), 32'd0);
         check("post_E", 32'(E), 32'd0);
      end

      // increment before any load/clear: compares suppressed
      run_cmd(2'b01, N'($urandom), 4'd2, 1'b0);
      run_cmd(2'b11, N'($urandom), 4'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run_cmd(2'($urandom), N'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
